inst_queue: RTL and testbench
=============================

INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: PC width.
REQ-002 Parameter DEPTH, default 4: entries; power of two, at least 2.
REQ-003 The block SHALL use one clock, clk_in, and reset rst_in, which is asynchronous and active-high.
REQ-004 Ports SHALL be:
- clk_in  in  1  clock
- rst_in  in  1  async active-high reset
- rdy_in  in  1  global ready; low freezes all state
- RBIQ_clear  in  1  flush on mispredict
- IFIQ_en  in  1  fetcher push valid
- IFIQ_pc  in  ADDR_WIDTH  PC of pushed instruction
- IFIQ_inst  in  32  raw instruction
- IFIQ_predict_result  in  1  0 = not taken, 1 = taken
- IQIF_full  out  1  queue full
- DPIQ_ask  in  1  dispatcher requests next instruction
- IQDC_en  out  1  issue valid pulse to decoder
- IQDC_pc  out  ADDR_WIDTH  issued PC
- IQDC_opcode  out  7  issued inst[6:0]
- IQDC_remain_inst  out  25  issued inst[31:7]
- IQDC_predict_result  out  1  issued prediction

Function
REQ-005 The block SHALL be a circular FIFO of DEPTH entries {pc, inst, predict} with head pointer, tail pointer and count; count width SHALL be log2(DEPTH)+1.
REQ-006 Pointers SHALL wrap modulo DEPTH.
REQ-007 IQIF_full SHALL be combinational: 1 iff count == DEPTH.
REQ-008 pop in a cycle SHALL be: rdy_in and not RBIQ_clear and DPIQ_ask and count > 0, with count taken before any push that cycle.
REQ-009 push in a cycle SHALL be: rdy_in and not RBIQ_clear and IFIQ_en and (count < DEPTH or pop).
REQ-010 An IFIQ_en asserted while count == DEPTH with no pop SHALL be dropped, leaving the queue unchanged.
REQ-011 On pop, the next edge SHALL register the head entry into IQDC_pc, IQDC_opcode, IQDC_remain_inst and IQDC_predict_result, set IQDC_en = 1, and advance head.
- Issue latency is one cycle from ask.
- No same-cycle bypass: an entry pushed in cycle N can pop no earlier than cycle N+1.
REQ-012 Without a pop, IQDC_en SHALL be 0 next cycle and the IQDC data outputs SHALL hold their values.
REQ-013 On push, the entry SHALL be written at tail and tail advanced.
REQ-014 On simultaneous push and pop, count SHALL be unchanged. Otherwise count SHALL move by +1 (push only) or -1 (pop only).
REQ-015 RBIQ_clear with rdy_in = 1 SHALL, at the next edge:
- set head, tail and count to 0 and IQDC_en to 0;
- ignore any same-cycle push and ask.
REQ-016 While rdy_in = 0:
- pointers, count and entries SHALL hold;
- IQDC_en SHALL be 0 next cycle, so no double issue occurs;
- RBIQ_clear SHALL be ignored.
REQ-017 Entry storage SHALL need no reset; only valid entries (between head and tail) are observable.
REQ-018 Instruction bits SHALL pass through unmodified: IQDC_opcode = inst[6:0], IQDC_remain_inst = inst[31:7].

Reset
REQ-019 When rst_in is high, the block SHALL immediately, without waiting for a clock edge, set:
- head, tail and count to 0;
- IQDC_en, IQDC_pc, IQDC_opcode, IQDC_remain_inst and IQDC_predict_result to 0;
- IQIF_full therefore to 0.
REQ-020 A reset asserted mid-operation SHALL discard all queued entries and any pending issue; the first issue after deassertion requires a fresh push.

Verification
REQ-021 Reset, then push pc=0x0, inst=0x00500093 (addi), predict=0, then DPIQ_ask one cycle later -> IQDC_en = 1 exactly one cycle after ask, IQDC_opcode = 0x13, IQDC_remain_inst = 0x000A001, IQDC_pc = 0x0.
REQ-022 Push 4 entries (pc 0x0,0x4,0x8,0xC) with no ask -> IQIF_full = 1; a 5th push of pc=0x10 is dropped; 4 asks then issue 0x0,0x4,0x8,0xC in order, and a 5th ask gives IQDC_en = 0.
REQ-023 Full queue with push pc=0x10 and ask in the same cycle -> pc 0x0 issues, 0x10 is accepted, count stays 4; later pops reach 0x10 last.
REQ-024 Wrap-around: 10 interleaved push/pop pairs (pc 0x0..0x24) -> every pc issues once, in order, with no loss across the pointer wrap.
REQ-025 3 entries queued, then RBIQ_clear together with push and ask -> next cycle IQDC_en = 0, count = 0, IQIF_full = 0; the following ask issues nothing until a new push.
REQ-026 rdy_in = 0 for 3 cycles while DPIQ_ask = 1 and IFIQ_en = 1 -> no issue and no count change; rst_in pulsed between edges immediately zeroes all outputs.

Source files
------------

// File: rtl/inst_queue.sv
// Instruction queue between fetcher and dispatcher: circular FIFO of
// {pc, inst, predict} entries with a registered one-cycle issue port.
module inst_queue #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  RBIQ_clear,
    input  logic                  IFIQ_en,
    input  logic [ADDR_WIDTH-1:0] IFIQ_pc,
    input  logic [31:0]           IFIQ_inst,
    input  logic                  IFIQ_predict_result,
    output logic                  IQIF_full,
    input  logic                  DPIQ_ask,
    output logic                  IQDC_en,
    output logic [ADDR_WIDTH-1:0] IQDC_pc,
    output logic [6:0]            IQDC_opcode,
    output logic [24:0]           IQDC_remain_inst,
    output logic                  IQDC_predict_result
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];
    logic [31:0]           inst_mem [DEPTH];
    logic                  pred_mem [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic pop_c;
    logic push_c;

    // Full flag follows the occupancy count directly.
    assign IQIF_full = (count == CNT_W'(DEPTH));

    // Pop/push qualification; pop uses the count before any push, so a
    // freshly pushed entry can never issue in its own cycle.
    always_comb begin
        pop_c  = 1'b0;
        push_c = 1'b0;
        if (rdy_in && !RBIQ_clear) begin
            pop_c  = DPIQ_ask && (count != '0);
            push_c = IFIQ_en && ((count != CNT_W'(DEPTH)) || pop_c);
        end
    end

    // Entry storage; contents outside head..tail are never observed.
    always_ff @(posedge clk_in) begin
        if (push_c) begin
            pc_mem[tail]   <= IFIQ_pc;
            inst_mem[tail] <= IFIQ_inst;
            pred_mem[tail] <= IFIQ_predict_result;
        end
    end

    // Pointers, count and the registered issue port.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head                <= '0;
            tail                <= '0;
            count               <= '0;
            IQDC_en             <= 1'b0;
            IQDC_pc             <= '0;
            IQDC_opcode         <= '0;
            IQDC_remain_inst    <= '0;
            IQDC_predict_result <= 1'b0;
        end else if (!rdy_in) begin
            IQDC_en <= 1'b0;
        end else if (RBIQ_clear) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            IQDC_en <= 1'b0;
        end else begin
            IQDC_en <= pop_c;
            if (pop_c) begin
                IQDC_pc             <= pc_mem[head];
                IQDC_opcode         <= inst_mem[head][6:0];
                IQDC_remain_inst    <= inst_mem[head][31:7];
                IQDC_predict_result <= pred_mem[head];
                head                <= head + PTR_W'(1);
            end
            if (push_c) begin
                tail <= tail + PTR_W'(1);
            end
            if (push_c && !pop_c) begin
                count <= count + CNT_W'(1);
            end else if (pop_c && !push_c) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: queue-based reference model,
// directed scenarios with pinned literal expectations, then random traffic.
module tb_inst_queue;

    localparam int unsigned AW    = 32;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          rdy;
    logic          clr;
    logic          en;
    logic [AW-1:0] pc;
    logic [31:0]   inst;
    logic          pred;
    logic          ask;

    logic          IQIF_full;
    logic          IQDC_en;
    logic [AW-1:0] IQDC_pc;
    logic [6:0]    IQDC_opcode;
    logic [24:0]   IQDC_remain_inst;
    logic          IQDC_predict_result;

    always #5 clk = ~clk;

    inst_queue #(.ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk_in              (clk),
        .rst_in              (rst),
        .rdy_in              (rdy),
        .RBIQ_clear          (clr),
        .IFIQ_en             (en),
        .IFIQ_pc             (pc),
        .IFIQ_inst           (inst),
        .IFIQ_predict_result (pred),
        .IQIF_full           (IQIF_full),
        .DPIQ_ask            (ask),
        .IQDC_en             (IQDC_en),
        .IQDC_pc             (IQDC_pc),
        .IQDC_opcode         (IQDC_opcode),
        .IQDC_remain_inst    (IQDC_remain_inst),
        .IQDC_predict_result (IQDC_predict_result)
    );

    typedef struct {
        logic [AW-1:0] pc;
        logic [31:0]   inst;
        logic          pred;
    } ent_t;

    ent_t          q[$];
    logic [AW-1:0] issued[$];
    logic          exp_en   = 1'b0;
    logic [AW-1:0] exp_pc   = '0;
    logic [31:0]   exp_inst = '0;
    logic          exp_pred = 1'b0;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Reference model advanced once per rising edge from the applied inputs.
    task automatic model_edge();
        bit   p;
        bit   u;
        ent_t e;
        if (!rdy) begin
            exp_en = 1'b0;
        end else if (clr) begin
            q.delete();
            exp_en = 1'b0;
        end else begin
            p = ask && (q.size() > 0);
            u = en && ((q.size() < int'(DEPTH)) || p);
            exp_en = p;
            if (p) begin
                e        = q.pop_front();
                exp_pc   = e.pc;
                exp_inst = e.inst;
                exp_pred = e.pred;
                issued.push_back(e.pc);
            end
            if (u) begin
                e.pc   = pc;
                e.inst = inst;
                e.pred = pred;
                q.push_back(e);
            end
        end
    endtask

    task automatic compare();
        chk("iqdc_en",     64'(IQDC_en),             64'(exp_en));
        chk("iqdc_pc",     64'(IQDC_pc),             64'(exp_pc));
        chk("iqdc_opcode", 64'(IQDC_opcode),         64'(exp_inst[6:0]));
        chk("iqdc_remain", 64'(IQDC_remain_inst),    64'(exp_inst[31:7]));
        chk("iqdc_pred",   64'(IQDC_predict_result), 64'(exp_pred));
        chk("iqif_full",   64'(IQIF_full),           64'(q.size() == int'(DEPTH)));
    endtask

    // Apply one cycle of inputs, advance the model at the edge, compare at negedge.
    task automatic cycle(input logic e, input logic [AW-1:0] p, input logic [31:0] i,
                         input logic pr, input logic a, input logic c, input logic r);
        en = e; pc = p; inst = i; pred = pr; ask = a; clr = c; rdy = r;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    function automatic logic [31:0] inst_of(input logic [AW-1:0] p);
        return {p[22:0] ^ 23'h5a5a5, 9'h0b3};
    endfunction

    task automatic push(input logic [AW-1:0] p);
        cycle(1'b1, p, inst_of(p), p[2], 1'b0, 1'b0, 1'b1);
    endtask

    task automatic ask_only();
        cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; clr = 1'b0; en = 1'b0; pc = '0; inst = '0; pred = 1'b0; ask = 1'b0;
        repeat (2) @(negedge clk);
        compare();
        chk("reset_full", 64'(IQIF_full), 64'd0);
        chk("reset_en",   64'(IQDC_en),   64'd0);
        rst = 1'b0;

        // Single addi push then ask one cycle later.
        cycle(1'b1, 32'h0, 32'h00500093, 1'b0, 1'b0, 1'b0, 1'b1);
        ask_only();
        chk("addi_en",     64'(IQDC_en),          64'd1);
        chk("addi_opcode", 64'(IQDC_opcode),      64'h13);
        chk("addi_remain", 64'(IQDC_remain_inst), 64'h000A001);
        chk("addi_pc",     64'(IQDC_pc),          64'h0);
        cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Fill, drop a 5th push, drain in order, extra ask issues nothing.
        issued.delete();
        for (int k = 0; k < 4; k++) push(AW'(4 * k));
        chk("fill_full", 64'(IQIF_full), 64'd1);
        push(32'h10);
        for (int k = 0; k < 5; k++) ask_only();
        chk("drain_extra_en", 64'(IQDC_en), 64'd0);
        chk("drain_cnt", 64'(issued.size()), 64'd4);
        for (int k = 0; k < 4 && k < issued.size(); k++)
            chk("drain_order", 64'(issued[k]), 64'(4 * k));

        // Full queue with push and ask together.
        issued.delete();
        for (int k = 0; k < 4; k++) push(AW'(4 * k));
        cycle(1'b1, 32'h10, inst_of(32'h10), 1'b0, 1'b1, 1'b0, 1'b1);
        chk("fullpp_pc",   64'(IQDC_pc),   64'h0);
        chk("fullpp_full", 64'(IQIF_full), 64'd1);
        chk("fullpp_size", 64'(q.size()),  64'd4);
        for (int k = 0; k < 4; k++) ask_only();
        chk("fullpp_last", 64'(IQDC_pc), 64'h10);

        // Interleaved push/pop across the pointer wrap.
        issued.delete();
        push(32'h0);
        for (int k = 1; k < 10; k++)
            cycle(1'b1, AW'(4 * k), inst_of(AW'(4 * k)), 1'b1, 1'b1, 1'b0, 1'b1);
        ask_only();
        chk("wrap_cnt", 64'(issued.size()), 64'd10);
        for (int k = 0; k < 10 && k < issued.size(); k++)
            chk("wrap_order", 64'(issued[k]), 64'(4 * k));

        // Flush with concurrent push and ask.
        for (int k = 0; k < 3; k++) push(AW'(32'h100 + 4 * k));
        cycle(1'b1, 32'h200, inst_of(32'h200), 1'b0, 1'b1, 1'b1, 1'b1);
        chk("flush_en",   64'(IQDC_en),   64'd0);
        chk("flush_full", 64'(IQIF_full), 64'd0);
        chk("flush_size", 64'(q.size()),  64'd0);
        ask_only();
        chk("flush_ask_en", 64'(IQDC_en), 64'd0);
        push(32'h300);
        ask_only();
        chk("flush_new_pc", 64'(IQDC_pc), 64'h300);

        // Stall with ask, push and clear all asserted.
        push(32'h400);
        push(32'h404);
        for (int k = 0; k < 3; k++)
            cycle(1'b1, 32'h500, inst_of(32'h500), 1'b0, 1'b1, k == 1, 1'b0);
        chk("stall_en",   64'(IQDC_en),  64'd0);
        chk("stall_size", 64'(q.size()), 64'd2);
        ask_only();
        chk("stall_pc", 64'(IQDC_pc), 64'h400);

        // Asynchronous reset mid-cycle with a queued entry and issued data.
        #2 rst = 1'b1;
        #1;
        chk("arst_en",     64'(IQDC_en),             64'd0);
        chk("arst_pc",     64'(IQDC_pc),             64'd0);
        chk("arst_opcode", 64'(IQDC_opcode),         64'd0);
        chk("arst_remain", 64'(IQDC_remain_inst),    64'd0);
        chk("arst_pred",   64'(IQDC_predict_result), 64'd0);
        chk("arst_full",   64'(IQIF_full),           64'd0);
        q.delete();
        exp_en = 1'b0; exp_pc = '0; exp_inst = '0; exp_pred = 1'b0;
        en = 1'b0; ask = 1'b0; clr = 1'b0; rdy = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        compare();
        ask_only();
        chk("arst_ask_en", 64'(IQDC_en), 64'd0);
        push(32'h600);
        ask_only();
        chk("arst_new_pc", 64'(IQDC_pc), 64'h600);

        // Random traffic against the model.
        for (int k = 0; k < 600; k++) begin
            cycle(1'($urandom_range(0, 99) < 60), AW'($urandom), $urandom, 1'($urandom),
                  1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 4),
                  1'($urandom_range(0, 99) < 85));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
